// File: rtl/vend_pkg.sv
// -----------------------------------------------------------------------------
// vend_pkg
// Shared definitions for the multi-product vending controller:
//   - vend_state_e : FSM state encoding (also driven on the 'state' output)
//   - DEF_*        : default width/size constants used as parameter defaults
// -----------------------------------------------------------------------------
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_REFUND  = 2'd3
  } vend_state_e;

  localparam int DEF_NUM_PRODUCTS = 4;
  localparam int DEF_PRICE_W      = 8;
  localparam int DEF_STOCK_W      = 4;
  localparam int DEF_SALES_W      = 16;
  localparam int DEF_INIT_STOCK   = 2;
  localparam int DEF_TIMEOUT_CYC  = 1000;

  // Product i lives in bits [i*8 +: 8]: product 0 costs 3, product 3 costs 9.
  localparam logic [DEF_NUM_PRODUCTS*DEF_PRICE_W-1:0] DEF_PRICE_TABLE =
    {8'd9, 8'd7, 8'd5, 8'd3};

endpackage

// File: rtl/vend_stock_bank.sv
// -----------------------------------------------------------------------------
// vend_stock_bank
// Per-product saturating stock counters.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   dec_en, dec_code            : take one item of product dec_code this cycle
//   restock_valid/code/qty      : add qty items to product restock_code
//   stock_flat                  : all counters, product i at [i*STOCK_W +: STOCK_W]
// A restock and a decrement on the same product in one cycle combine before
// saturation, so the result is sat(stock + qty - 1).
// -----------------------------------------------------------------------------
module vend_stock_bank
  import vend_pkg::*;
#(
  parameter int NUM_PRODUCTS = DEF_NUM_PRODUCTS,
  parameter int STOCK_W      = DEF_STOCK_W,
  parameter int INIT_STOCK   = DEF_INIT_STOCK
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              dec_en,
  input  logic [$clog2(NUM_PRODUCTS)-1:0]   dec_code,
  input  logic                              restock_valid,
  input  logic [$clog2(NUM_PRODUCTS)-1:0]   restock_code,
  input  logic [STOCK_W-1:0]                restock_qty,
  output logic [NUM_PRODUCTS*STOCK_W-1:0]   stock_flat
);

  localparam int CW = $clog2(NUM_PRODUCTS);

  // One extra bit holds the carry of stock+qty; a set top bit means saturate.
  function automatic logic [STOCK_W-1:0] next_count(
    input logic [STOCK_W-1:0] cur,
    input logic               add_en,
    input logic [STOCK_W-1:0] qty,
    input logic               dec
  );
    logic [STOCK_W:0] sum;
    // NOTE: blocking '=' is right inside functions and always_comb (ordered
    // temporaries); registers are only ever written with '<=' in always_ff.
    sum = {1'b0, cur} + (add_en ? {1'b0, qty} : '0);
    if (dec && (sum != '0)) sum = sum - 1'b1;
    return sum[STOCK_W] ? '1 : sum[STOCK_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (rst) begin
        stock_flat[i*STOCK_W +: STOCK_W] <= STOCK_W'(INIT_STOCK);
      end else begin
        stock_flat[i*STOCK_W +: STOCK_W] <= next_count(
          stock_flat[i*STOCK_W +: STOCK_W],
          restock_valid && (restock_code == CW'(i)),
          restock_qty,
          dec_en && (dec_code == CW'(i)));
      end
    end
  end

endmodule

// File: rtl/vend_ctrl_multi.sv
// -----------------------------------------------------------------------------
// vend_ctrl_multi
// Multi-product vending controller: collects coins, vends on confirm if the
// product is stocked and affordable, returns change, refunds on cancel.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   coin_valid, coin_value        : one-cycle coin strobe and its worth
//   confirm, sel_code             : purchase request for product sel_code
//   cancel                        : refund request
//   restock_valid/code/qty        : add stock to one product (any state)
//   credit, state, sales_total    : registered status
//   stock_flat                    : per-product stock, product i at [i*STOCK_W +: STOCK_W]
//   dispense_valid/code           : one-cycle pulse while vending
//   change_valid/value            : one-cycle pulse while refunding
//   coin_reject, alarm            : one-cycle error pulses
// Build option: define VEND_TIMEOUT_EN to refund credit after TIMEOUT_CYC
// quiet cycles in COLLECT; otherwise no inactivity counter exists.
// -----------------------------------------------------------------------------
module vend_ctrl_multi
  import vend_pkg::*;
#(
  parameter int NUM_PRODUCTS = DEF_NUM_PRODUCTS,
  parameter int PRICE_W      = DEF_PRICE_W,
  parameter int STOCK_W      = DEF_STOCK_W,
  parameter int SALES_W      = DEF_SALES_W,
  parameter logic [NUM_PRODUCTS*PRICE_W-1:0] PRICE_TABLE = DEF_PRICE_TABLE,
  parameter int INIT_STOCK   = DEF_INIT_STOCK,
  parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              coin_valid,
  input  logic [PRICE_W-1:0]                coin_value,
  input  logic                              confirm,
  input  logic [$clog2(NUM_PRODUCTS)-1:0]   sel_code,
  input  logic                              cancel,
  input  logic                              restock_valid,
  input  logic [$clog2(NUM_PRODUCTS)-1:0]   restock_code,
  input  logic [STOCK_W-1:0]                restock_qty,
  output logic [PRICE_W-1:0]                credit,
  output logic [1:0]                        state,
  output logic [SALES_W-1:0]                sales_total,
  output logic [NUM_PRODUCTS*STOCK_W-1:0]   stock_flat,
  output logic                              dispense_valid,
  output logic [$clog2(NUM_PRODUCTS)-1:0]   dispense_code,
  output logic                              change_valid,
  output logic [PRICE_W-1:0]                change_value,
  output logic                              coin_reject,
  output logic                              alarm
);

  localparam int CW = $clog2(NUM_PRODUCTS);

  vend_state_e        state_q;
  logic [PRICE_W-1:0] credit_q;
  logic [SALES_W-1:0] sales_q;
  logic [CW-1:0]      sel_q;

  logic [PRICE_W:0]   coin_sum;
  logic               coin_ovf;
  logic [PRICE_W-1:0] credit_acc;   // credit after this cycle's coin, if accepted
  logic [PRICE_W-1:0] price_sel;
  logic [PRICE_W-1:0] price_vend;
  logic [STOCK_W-1:0] stock_sel;
  logic               sel_in_range;
  logic               buy_ok;
  logic [PRICE_W-1:0] credit_vend;
  logic               timeout_hit;

  assign coin_sum    = {1'b0, credit_q} + {1'b0, coin_value};
  assign coin_ovf    = coin_sum[PRICE_W];
  assign credit_acc  = (coin_valid && !coin_ovf) ? coin_sum[PRICE_W-1:0] : credit_q;
  assign credit_vend = credit_q - price_vend;

  // Table lookups for the requested product and the latched vend product.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned (which would infer a latch).
    price_sel    = '0;
    price_vend   = '0;
    stock_sel    = '0;
    sel_in_range = 1'b0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (sel_code == CW'(i)) begin
        price_sel    = PRICE_TABLE[i*PRICE_W +: PRICE_W];
        stock_sel    = stock_flat[i*STOCK_W +: STOCK_W];
        sel_in_range = 1'b1;
      end
      if (sel_q == CW'(i)) price_vend = PRICE_TABLE[i*PRICE_W +: PRICE_W];
    end
  end

  // Affordability uses credit before any same-cycle coin.
  assign buy_ok = sel_in_range && (stock_sel != '0) && (credit_q >= price_sel);

`ifdef VEND_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TW-1:0] idle_cnt;
  logic          activity;

  assign activity    = coin_valid | confirm | cancel;
  assign timeout_hit = (state_q == ST_COLLECT) && !activity &&
                       (idle_cnt == TW'(TIMEOUT_CYC - 1));

  // Outside COLLECT the counter is held at zero, which also clears it on entry.
  always_ff @(posedge clk) begin
    if (rst || (state_q != ST_COLLECT) || activity || timeout_hit) idle_cnt <= '0;
    else                                                           idle_cnt <= idle_cnt + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  vend_stock_bank #(
    .NUM_PRODUCTS (NUM_PRODUCTS),
    .STOCK_W      (STOCK_W),
    .INIT_STOCK   (INIT_STOCK)
  ) u_stock (
    .clk           (clk),
    .rst           (rst),
    .dec_en        (state_q == ST_VEND),
    .dec_code      (sel_q),
    .restock_valid (restock_valid),
    .restock_code  (restock_code),
    .restock_qty   (restock_qty),
    .stock_flat    (stock_flat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      credit_q       <= '0;
      sales_q        <= '0;
      sel_q          <= '0;
      dispense_valid <= 1'b0;
      dispense_code  <= '0;
      change_valid   <= 1'b0;
      change_value   <= '0;
      coin_reject    <= 1'b0;
      alarm          <= 1'b0;
    end else begin
      // Pulses default low; a state below raises the ones it owns.
      dispense_valid <= 1'b0;
      dispense_code  <= '0;
      change_valid   <= 1'b0;
      change_value   <= '0;
      coin_reject    <= 1'b0;
      alarm          <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (coin_valid) begin
            credit_q <= coin_value;
            state_q  <= ST_COLLECT;
          end
        end

        ST_COLLECT: begin
          if (coin_valid && coin_ovf) coin_reject <= 1'b1;
          credit_q <= credit_acc;
          if (cancel || timeout_hit) begin
            state_q      <= ST_REFUND;
            change_valid <= 1'b1;
            change_value <= credit_acc;
          end else if (confirm) begin
            if (buy_ok) begin
              state_q        <= ST_VEND;
              sel_q          <= sel_code;
              dispense_valid <= 1'b1;
              dispense_code  <= sel_code;
            end else begin
              alarm <= 1'b1;
            end
          end
        end

        ST_VEND: begin
          coin_reject <= coin_valid;
          credit_q    <= credit_vend;
          sales_q     <= sales_q + SALES_W'(price_vend);
          if (credit_vend != '0) begin
            state_q      <= ST_REFUND;
            change_valid <= 1'b1;
            change_value <= credit_vend;
          end else begin
            state_q <= ST_IDLE;
          end
        end

        ST_REFUND: begin
          coin_reject <= coin_valid;
          credit_q    <= '0;
          state_q     <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign credit      = credit_q;
  assign state       = state_q;
  assign sales_total = sales_q;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// -----------------------------------------------------------------------------
// tb_vend_ctrl_multi
// Directed scenarios plus randomized traffic against a behavioural model of
// the vending rules. The model tracks a phase, credit, sales and a stock array
// as plain integers and states the expected registered outputs after each
// edge. Define VEND_TIMEOUT_EN in both RTL and bench builds to cover the
// inactivity refund (TIMEOUT_CYC is set to 8 here).
// -----------------------------------------------------------------------------
module tb_vend_ctrl_multi;

  localparam int NP   = 4;
  localparam int PW   = 8;
  localparam int SW   = 4;
  localparam int SLW  = 16;
  localparam int CW   = 2;
  localparam int TOUT = 8;
  localparam int PMAX = (1 << PW) - 1;
  localparam int SMAX = (1 << SW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              coin_valid;
  logic [PW-1:0]     coin_value;
  logic              confirm;
  logic [CW-1:0]     sel_code;
  logic              cancel;
  logic              restock_valid;
  logic [CW-1:0]     restock_code;
  logic [SW-1:0]     restock_qty;
  logic [PW-1:0]     credit;
  logic [1:0]        state;
  logic [SLW-1:0]    sales_total;
  logic [NP*SW-1:0]  stock_flat;
  logic              dispense_valid;
  logic [CW-1:0]     dispense_code;
  logic              change_valid;
  logic [PW-1:0]     change_value;
  logic              coin_reject;
  logic              alarm;

  always #5 clk = ~clk;

  vend_ctrl_multi #(
    .NUM_PRODUCTS (NP),
    .PRICE_W      (PW),
    .STOCK_W      (SW),
    .SALES_W      (SLW),
    .PRICE_TABLE  ({8'd9, 8'd7, 8'd5, 8'd3}),
    .INIT_STOCK   (2),
    .TIMEOUT_CYC  (TOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .coin_valid     (coin_valid),
    .coin_value     (coin_value),
    .confirm        (confirm),
    .sel_code       (sel_code),
    .cancel         (cancel),
    .restock_valid  (restock_valid),
    .restock_code   (restock_code),
    .restock_qty    (restock_qty),
    .credit         (credit),
    .state          (state),
    .sales_total    (sales_total),
    .stock_flat     (stock_flat),
    .dispense_valid (dispense_valid),
    .dispense_code  (dispense_code),
    .change_valid   (change_valid),
    .change_value   (change_value),
    .coin_reject    (coin_reject),
    .alarm          (alarm)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    else             n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 collecting, 2 vending, 3 refunding
  int prices [NP] = '{3, 5, 7, 9};
  int m_phase, m_credit, m_sales, m_sel, m_quiet;
  int m_stock [NP];
  int e_disp, e_dcode, e_chg, e_cval, e_rej, e_alarm;

  task automatic model_step();
    int ph, cr, sum, s, price;
    bit act, stay;
    e_disp = 0; e_dcode = 0; e_chg = 0; e_cval = 0; e_rej = 0; e_alarm = 0;
    if (rst) begin
      m_phase = 0; m_credit = 0; m_sales = 0; m_sel = 0; m_quiet = 0;
      for (int i = 0; i < NP; i++) m_stock[i] = 2;
      return;
    end
    ph  = m_phase;
    cr  = m_credit;
    act = coin_valid || confirm || cancel;
    case (ph)
      0: begin
        m_quiet = 0;
        if (coin_valid) begin m_credit = int'(coin_value); m_phase = 1; end
      end
      1: begin
        sum  = cr + int'(coin_value);
        stay = 1'b1;
        if (coin_valid) begin
          if (sum > PMAX) e_rej = 1;
          else            m_credit = sum;
        end
        if (cancel
`ifdef VEND_TIMEOUT_EN
            || (!act && m_quiet == TOUT - 1)
`endif
           ) begin
          m_phase = 3; e_chg = 1; e_cval = m_credit; stay = 1'b0;
        end else if (confirm) begin
          if (int'(sel_code) < NP && m_stock[sel_code] > 0 && cr >= prices[sel_code]) begin
            m_phase = 2; m_sel = int'(sel_code); e_disp = 1; e_dcode = int'(sel_code);
            stay = 1'b0;
          end else begin
            e_alarm = 1;
          end
        end
        m_quiet = (stay && !act) ? m_quiet + 1 : 0;
      end
      2: begin
        price    = prices[m_sel];
        m_credit = cr - price;
        m_sales  = (m_sales + price) % (1 << SLW);
        e_rej    = coin_valid ? 1 : 0;
        if (m_credit > 0) begin m_phase = 3; e_chg = 1; e_cval = m_credit; end
        else              m_phase = 0;
      end
      default: begin
        m_credit = 0; m_phase = 0;
        e_rej    = coin_valid ? 1 : 0;
      end
    endcase
    for (int i = 0; i < NP; i++) begin
      s = m_stock[i];
      if (restock_valid && int'(restock_code) == i) s += int'(restock_qty);
      if (ph == 2 && m_sel == i) s -= 1;
      m_stock[i] = (s > SMAX) ? SMAX : s;
    end
  endtask

  function automatic logic [NP*SW-1:0] model_stock_flat();
    logic [NP*SW-1:0] v;
    v = '0;
    for (int i = 0; i < NP; i++) v[i*SW +: SW] = SW'(m_stock[i]);
    return v;
  endfunction

  task automatic compare_outputs();
    check("state",          32'(state),          32'(m_phase));
    check("credit",         32'(credit),         32'(m_credit));
    check("sales_total",    32'(sales_total),    32'(m_sales));
    check("stock_flat",     32'(stock_flat),     32'(model_stock_flat()));
    check("dispense_valid", 32'(dispense_valid), 32'(e_disp));
    check("dispense_code",  32'(dispense_code),  32'(e_dcode));
    check("change_valid",   32'(change_valid),   32'(e_chg));
    check("change_value",   32'(change_value),   32'(e_cval));
    check("coin_reject",    32'(coin_reject),    32'(e_rej));
    check("alarm",          32'(alarm),          32'(e_alarm));
  endtask

  task automatic clear_strobes();
    coin_valid = 1'b0; coin_value = '0; confirm = 1'b0; sel_code = '0;
    cancel = 1'b0; restock_valid = 1'b0; restock_code = '0; restock_qty = '0;
  endtask

  // One clock: model and DUT see the same inputs, outputs compared 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_outputs();
    clear_strobes();
  endtask

  task automatic coin(input int v);
    coin_valid = 1'b1; coin_value = PW'(v); tick();
  endtask

  task automatic buy(input int sel);
    confirm = 1'b1; sel_code = CW'(sel); tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_strobes();
    do_reset();
    check("lit_reset_state",  32'(state),       0);
    check("lit_reset_stock",  32'(stock_flat),  32'h2222);
    check("lit_reset_credit", 32'(credit),      0);

    // Coins 5,5, buy product 2 (price 7): dispense, then change of 3.
    coin(5); coin(5); buy(2);
    check("lit_disp_valid", 32'(dispense_valid), 1);
    check("lit_disp_code",  32'(dispense_code),  2);
    tick();
    check("lit_sales_7",    32'(sales_total),    7);
    check("lit_change_3",   32'(change_value),   3);
    check("lit_change_vld", 32'(change_valid),   1);
    tick();
    check("lit_back_idle",  32'(state),          0);

    // Credit 3 cannot buy product 3 (price 9): alarm, then cancel refunds 3.
    coin(3); buy(3);
    check("lit_alarm",      32'(alarm),  1);
    check("lit_credit_3",   32'(credit), 3);
    cancel = 1'b1; tick();
    check("lit_refund_3",   32'(change_value), 3);
    tick();
    check("lit_credit_0",   32'(credit), 0);

    // Three exact-coin purchases of product 0; the third finds no stock.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      coin(3); buy(0);
      check("lit_buy0_disp", 32'(dispense_valid), 1);
      tick();
    end
    check("lit_stock0_empty", 32'(stock_flat[3:0]), 0);
    coin(3); buy(0);
    check("lit_buy0_alarm", 32'(alarm), 1);
    cancel = 1'b1; tick(); tick();
    restock_valid = 1'b1; restock_code = 2'd0; restock_qty = 4'd15; tick();
    check("lit_restock_15", 32'(stock_flat[3:0]), 15);
    restock_valid = 1'b1; restock_code = 2'd0; restock_qty = 4'd15; tick();
    check("lit_restock_sat", 32'(stock_flat[3:0]), 15);

    // Restock during the vend of the same product: 2 + 1 - 1 = 2.
    coin(9); buy(3);
    restock_valid = 1'b1; restock_code = 2'd3; restock_qty = 4'd1; tick();
    check("lit_restock_net", 32'(stock_flat[15:12]), 2);

    // Overflowing coin is rejected; confirm + cancel together refunds 250.
    coin(250); coin(10);
    check("lit_coin_reject", 32'(coin_reject), 1);
    check("lit_credit_250",  32'(credit),      250);
    confirm = 1'b1; sel_code = 2'd0; cancel = 1'b1; tick();
    check("lit_refund_250",  32'(change_value), 250);
    check("lit_no_dispense", 32'(dispense_valid), 0);
    tick();

    // Inactivity in COLLECT.
    coin(4);
`ifdef VEND_TIMEOUT_EN
    repeat (TOUT - 1) tick();
    check("lit_tout_not_yet", 32'(change_valid), 0);
    tick();
    check("lit_tout_refund",  32'(change_valid), 1);
    check("lit_tout_value",   32'(change_value), 4);
    tick();
`else
    repeat (100) tick();
    check("lit_no_tout_state",  32'(state),  1);
    check("lit_no_tout_credit", 32'(credit), 4);
    cancel = 1'b1; tick(); tick();
`endif

    // Reset during VEND discards everything without change.
    coin(5); buy(0);
    check("lit_in_vend", 32'(state), 2);
    rst = 1'b1; tick(); rst = 1'b0;
    check("lit_rst_state",  32'(state),        0);
    check("lit_rst_credit", 32'(credit),       0);
    check("lit_rst_sales",  32'(sales_total),  0);
    check("lit_rst_stock",  32'(stock_flat),   32'h2222);
    check("lit_rst_nochg",  32'(change_valid), 0);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      rst           = ($urandom_range(0, 299) == 0);
      coin_valid    = ($urandom_range(0, 9) < 3);
      coin_value    = ($urandom_range(0, 7) == 0) ? PW'($urandom_range(100, 255))
                                                  : PW'($urandom_range(1, 20));
      confirm       = ($urandom_range(0, 4) == 0);
      sel_code      = CW'($urandom_range(0, NP - 1));
      cancel        = ($urandom_range(0, 19) == 0);
      restock_valid = ($urandom_range(0, 19) == 0);
      restock_code  = CW'($urandom_range(0, NP - 1));
      restock_qty   = SW'($urandom_range(0, SMAX));
      tick();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
